// File: rtl/conv_padding_gen_if.sv
// Valid/ready beat stream used for the feature input and the padded output.
// Pure wiring, no latency; the master holds data/vld until the slave asserts rdy.
// Master drives data/vld, slave drives rdy.
interface conv_padding_gen_if #(
  parameter int DATA_W = 64
) ();
  logic [DATA_W-1:0] data;
  logic              vld;
  logic              rdy;

  modport master (output data, output vld, input rdy);
  modport slave  (input data, input vld, output rdy);
endinterface

// File: rtl/conv_padding_gen.sv
// Wraps a batch of R x C feature beats with programmable zero borders, raster order.
// Latency: one cycle from generation (input handshake or border slot) to out vld.
// Backpressure: registered output stalls on !dst.rdy; src.rdy only on interior beats with a free slot.
module conv_padding_gen #(
  parameter int                DATA_W    = 64,
  parameter int                COL_W     = 9,
  parameter int                ROW_W     = 7,
  parameter int                PAD_W     = 2,
  parameter logic [DATA_W-1:0] PAD_VALUE = '0
) (
  input  logic                  sclk,
  input  logic                  s_rst,
  input  logic                  cfg_start,
  input  logic [COL_W-1:0]      cfg_feature_col,
  input  logic [ROW_W-1:0]      cfg_feature_row,
  input  logic [PAD_W-1:0]      cfg_pad_top,
  input  logic [PAD_W-1:0]      cfg_pad_bot,
  input  logic [PAD_W-1:0]      cfg_pad_left,
  input  logic [PAD_W-1:0]      cfg_pad_right,
  conv_padding_gen_if.slave     src,
  conv_padding_gen_if.master    dst,
  output logic                  busy,
  output logic                  done,
  output logic [ROW_W:0]        row_cnt,
  output logic [COL_W:0]        col_cnt
);
  localparam int CW = COL_W + 1;
  localparam int RW = ROW_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [COL_W-1:0] c_q;
  logic [ROW_W-1:0] r_q;
  logic [PAD_W-1:0] pt_q, pb_q, pl_q, pr_q;
  logic             done_nxt;
  logic             slot_free, interior, last, load, start_ok;
  logic [CW-1:0]    grid_w, col_lo, col_hi;
  logic [RW-1:0]    grid_h, row_lo, row_hi;

  // Grid geometry from the latched config; one extra bit keeps W/H from wrapping.
  assign col_lo    = CW'(pl_q);
  assign col_hi    = CW'(pl_q) + CW'(c_q);
  assign grid_w    = col_hi + CW'(pr_q);
  assign row_lo    = RW'(pt_q);
  assign row_hi    = RW'(pt_q) + RW'(r_q);
  assign grid_h    = row_hi + RW'(pb_q);
  assign interior  = (row_cnt >= row_lo) && (row_cnt < row_hi) &&
                     (col_cnt >= col_lo) && (col_cnt < col_hi);
  assign last      = (row_cnt == grid_h - RW'(1)) && (col_cnt == grid_w - CW'(1));
  assign slot_free = !dst.vld || dst.rdy;
  assign start_ok  = cfg_start && (cfg_feature_col != '0) && (cfg_feature_row != '0);
  assign busy      = (state != IDLE);

  // State register.
  always_ff @(posedge sclk) begin
    if (s_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, input ready and output-register load enable.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    load      = 1'b0;
    src.rdy   = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok)       state_nxt = RUN;
        else if (cfg_start) done_nxt  = 1'b1;
      end
      RUN: begin
        // Border beats never wait on the input stream.
        src.rdy = interior && slot_free;
        load    = slot_free && (!interior || src.vld);
        if (load && last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (dst.vld && dst.rdy) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latch the batch config on an accepted start; ignored while busy.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      c_q  <= '0;
      r_q  <= '0;
      pt_q <= '0;
      pb_q <= '0;
      pl_q <= '0;
      pr_q <= '0;
    end else if (state == IDLE && start_ok) begin
      c_q  <= cfg_feature_col;
      r_q  <= cfg_feature_row;
      pt_q <= cfg_pad_top;
      pb_q <= cfg_pad_bot;
      pl_q <= cfg_pad_left;
      pr_q <= cfg_pad_right;
    end
  end

  // Raster position of the next beat to generate; parked at 0 outside a batch.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      row_cnt <= '0;
      col_cnt <= '0;
    end else if ((state == IDLE && start_ok) || (state == DRAIN && state_nxt == IDLE)) begin
      row_cnt <= '0;
      col_cnt <= '0;
    end else if (load) begin
      if (col_cnt == grid_w - CW'(1)) begin
        col_cnt <= '0;
        row_cnt <= row_cnt + RW'(1);
      end else begin
        col_cnt <= col_cnt + CW'(1);
      end
    end
  end

  // Output register: holds while stalled, drops vld once taken with nothing new.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      dst.data <= PAD_VALUE;
      dst.vld  <= 1'b0;
    end else if (load) begin
      dst.data <= interior ? src.data : PAD_VALUE;
      dst.vld  <= 1'b1;
    end else if (dst.rdy) begin
      dst.vld  <= 1'b0;
    end
  end

  // Single-cycle completion pulse.
  always_ff @(posedge sclk) begin
    if (s_rst) done <= 1'b0;
    else       done <= done_nxt;
  end
endmodule
